// File: rtl/iso15693_tx_encoder.sv
// ISO15693 reader-to-tag 1-of-4 transmit encoder: SOF, byte stream via a one-entry
// holding buffer, EOF. mod drives the HF stage (1 = carrier off).
module iso15693_tx_encoder (
   input  logic       ck_1356meg,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       mod,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   typedef enum logic [1:0] {StIdle, StSof, StData, StEof} state_t;

   state_t     st_q, st_d;
   logic [6:0] cyc_q, cyc_d;
   logic [2:0] slot_q, slot_d;
   logic [1:0] pair_q, pair_d;
   logic [7:0] shift_q, shift_d;
   logic       cur_last_q, cur_last_d;
   logic [7:0] buf_q, buf_d;
   logic       buf_last_q, buf_last_d;
   logic       buf_full_q, buf_full_d;
   logic       last_seen_q, last_seen_d;
   logic       ready_en_q;
   logic       mod_q, mod_d;
   logic       frame_done_q, frame_done_d;
   logic       underrun_q, underrun_d;
   logic       acc, cyc_end, byte_end, xfer;

   assign cyc_end  = (cyc_q == 7'd127);
   assign byte_end = (st_q == StData) && (pair_q == 2'd3) && (slot_q == 3'd7) && cyc_end;
   // The buffer frees up on the transfer edge itself, so a byte can be taken then too.
   assign xfer     = byte_end && !cur_last_q && buf_full_q;
   assign tx_ready = ready_en_q && !last_seen_q &&
                     ((st_q == StIdle) ||
                      (((st_q == StSof) || (st_q == StData)) && (!buf_full_q || xfer)));
   assign acc        = tx_valid && tx_ready;
   assign mod        = mod_q;
   assign busy       = (st_q != StIdle);
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

   always_comb begin
      st_d         = st_q;
      cyc_d        = cyc_q;
      slot_d       = slot_q;
      pair_d       = pair_q;
      shift_d      = shift_q;
      cur_last_d   = cur_last_q;
      buf_d        = buf_q;
      buf_last_d   = buf_last_q;
      buf_full_d   = buf_full_q;
      last_seen_d  = last_seen_q;
      underrun_d   = 1'b0;
      mod_d        = 1'b0;
      frame_done_d = 1'b0;

      if (st_q != StIdle) begin
         cyc_d = cyc_q + 7'd1;
      end
      if (acc && (st_q != StIdle)) begin
         buf_d       = tx_data;
         buf_last_d  = tx_last;
         buf_full_d  = 1'b1;
         last_seen_d = last_seen_q | tx_last;
      end

      case (st_q)
         StIdle: begin
            if (acc) begin
               st_d        = StSof;
               cyc_d       = 7'd0;
               slot_d      = 3'd0;
               pair_d      = 2'd0;
               shift_d     = tx_data;
               cur_last_d  = tx_last;
               last_seen_d = tx_last;
            end
         end
         StSof: begin
            if (cyc_end) begin
               slot_d = slot_q + 3'd1;
               if (slot_q == 3'd7) st_d = StData;
            end
         end
         StData: begin
            if (cyc_end) begin
               slot_d = slot_q + 3'd1;
               if (slot_q == 3'd7) begin
                  pair_d  = pair_q + 2'd1;
                  shift_d = {2'b00, shift_q[7:2]};
                  if (pair_q == 2'd3) begin
                     if (cur_last_q) begin
                        st_d = StEof;
                     end else if (buf_full_q) begin
                        shift_d    = buf_q;
                        cur_last_d = buf_last_q;
                        buf_full_d = acc;
                     end else if (acc) begin
                        shift_d    = tx_data;
                        cur_last_d = tx_last;
                        buf_full_d = 1'b0;
                     end else begin
                        st_d       = StEof;
                        underrun_d = 1'b1;
                     end
                  end
               end
            end
         end
         StEof: begin
            if (cyc_end) begin
               if (slot_q == 3'd3) begin
                  st_d        = StIdle;
                  cyc_d       = 7'd0;
                  slot_d      = 3'd0;
                  pair_d      = 2'd0;
                  last_seen_d = 1'b0;
               end else begin
                  slot_d = slot_q + 3'd1;
               end
            end
         end
         default: st_d = StIdle;
      endcase

      // mod is registered from the next-cycle position so it only moves on slot edges.
      case (st_d)
         StSof:   mod_d = (slot_d == 3'd0) || (slot_d == 3'd5);
         StData:  mod_d = (slot_d == {shift_d[1:0], 1'b1});
         StEof:   mod_d = (slot_d == 3'd2);
         default: mod_d = 1'b0;
      endcase
      frame_done_d = (st_d == StEof) && (slot_d == 3'd3) && (cyc_d == 7'd127);
   end

   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= StIdle;
         cyc_q        <= 7'd0;
         slot_q       <= 3'd0;
         pair_q       <= 2'd0;
         shift_q      <= 8'd0;
         cur_last_q   <= 1'b0;
         buf_q        <= 8'd0;
         buf_last_q   <= 1'b0;
         buf_full_q   <= 1'b0;
         last_seen_q  <= 1'b0;
         ready_en_q   <= 1'b0;
         mod_q        <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         st_q         <= st_d;
         cyc_q        <= cyc_d;
         slot_q       <= slot_d;
         pair_q       <= pair_d;
         shift_q      <= shift_d;
         cur_last_q   <= cur_last_d;
         buf_q        <= buf_d;
         buf_last_q   <= buf_last_d;
         buf_full_q   <= buf_full_d;
         last_seen_q  <= last_seen_d;
         ready_en_q   <= 1'b1;
         mod_q        <= mod_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

endmodule

// File: tb/tb_iso15693_tx_encoder.sv
// Scoreboard bench for iso15693_tx_encoder: expected mod edges and pulses are queued
// per frame segment; a monitor pops them as the DUT produces them.
module tb_iso15693_tx_encoder;

   localparam int KRise = 0;
   localparam int KFall = 1;
   localparam int KUnd  = 2;
   localparam int KDone = 3;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, mod, busy, frame_done, underrun;

   int  cnt = 0;
   int  errors = 0;
   int  checks = 0;
   ev_t exp_q[$];
   logic prev_mod = 1'b0;

   iso15693_tx_encoder dut (
      .ck_1356meg (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .mod        (mod),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 1;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cnt=%0d)", name, got, want, cnt);
      end
   endtask

   task automatic push(input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // h is the posedge index of the first byte's handshake; cycle k of the frame is
   // observed with cnt == h + k - 1.
   task automatic push_sof(input int h);
      push(KRise, h);       push(KFall, h + 128);
      push(KRise, h + 640); push(KFall, h + 768);
   endtask

   task automatic push_byte(input int h, input int idx, input logic [7:0] d);
      int base, v, s;
      base = h + 1024 + idx * 4096;
      for (int p = 0; p < 4; p++) begin
         v = (int'(d) >> (2 * p)) & 3;
         s = base + p * 1024 + (2 * v + 1) * 128;
         push(KRise, s);
         push(KFall, s + 128);
      end
   endtask

   task automatic push_eof(input int h, input int n, input bit ur);
      int e;
      e = h + 1024 + n * 4096;
      if (ur) push(KUnd, e);
      push(KRise, e + 256);
      push(KFall, e + 384);
      push(KDone, e + 511);
   endtask

   // Called at a negedge; returns at the negedge after the handshake with h set.
   task automatic offer(input logic [7:0] d, input logic l, output int h);
      int n;
      n = 0;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      while (!tx_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) check("handshake_timeout", 0, 1);
      h = cnt + 1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, int'(busy), 0);
      repeat (3) @(negedge clk);
      check({name, "_queue_drained"}, exp_q.size(), 0);
      check({name, "_ready_idle"}, int'(tx_ready), 1);
   endtask

   task automatic observe(input int k);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event_kind", k, -1);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", k, e.kind);
         check("event_cycle", cnt, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (mod !== prev_mod) observe(mod ? KRise : KFall);
      if (underrun) observe(KUnd);
      if (frame_done) begin
         observe(KDone);
         check("busy_at_frame_done", int'(busy), 1);
      end
      prev_mod = mod;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish (cnt=%0d)", cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int h, h2;
      repeat (3) @(negedge clk);
      check("rst_mod", int'(mod), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(tx_ready), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_underrun", int'(underrun), 0);
      rst_n = 1'b1;
      #1 check("ready_before_first_edge", int'(tx_ready), 0);
      @(negedge clk);
      check("ready_after_release", int'(tx_ready), 1);

      // single byte 0x00, last
      offer(8'h00, 1'b1, h);
      push_sof(h); push_byte(h, 0, 8'h00); push_eof(h, 1, 1'b0);
      repeat (5) @(negedge clk);
      check("ready_low_after_last", int'(tx_ready), 0);
      check("busy_in_sof", int'(busy), 1);
      wait_idle("b00");

      // 0xE4: pairs 0,1,2,3
      offer(8'hE4, 1'b1, h);
      push_sof(h); push_byte(h, 0, 8'hE4); push_eof(h, 1, 1'b0);
      wait_idle("bE4");

      // three streamed bytes with tx_valid held
      offer(8'h26, 1'b0, h);
      push_sof(h); push_byte(h, 0, 8'h26);
      offer(8'h01, 1'b0, h2);
      push_byte(h, 1, 8'h01);
      offer(8'h00, 1'b1, h2);
      push_byte(h, 2, 8'h00); push_eof(h, 3, 1'b0);
      check("ready_low_after_stream_last", int'(tx_ready), 0);
      wait_idle("stream3");

      // no follow-up byte: underrun
      offer(8'h55, 1'b0, h);
      push_sof(h); push_byte(h, 0, 8'h55); push_eof(h, 1, 1'b1);
      wait_idle("under");

      // third byte offered exactly on the buffer-to-shift edge
      offer(8'h3C, 1'b0, h);
      push_sof(h); push_byte(h, 0, 8'h3C);
      offer(8'hA5, 1'b0, h2);
      push_byte(h, 1, 8'hA5);
      while (cnt < h + 5118) @(negedge clk);
      check("ready_buffer_full", int'(tx_ready), 0);
      @(negedge clk);
      tx_data = 8'h81; tx_last = 1'b1; tx_valid = 1'b1;
      check("ready_on_transfer", int'(tx_ready), 1);
      @(negedge clk);
      tx_valid = 1'b0;
      push_byte(h, 2, 8'h81); push_eof(h, 3, 1'b0);
      wait_idle("xfer");

      // reset during DATA slot 3 of the first pair
      offer(8'h1B, 1'b1, h);
      push_sof(h);
      while (cnt < h + 1024 + 384 + 10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_mod", int'(mod), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_ready", int'(tx_ready), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 check("midrst_ready_before_edge", int'(tx_ready), 0);
      @(negedge clk);
      check("midrst_ready_after", int'(tx_ready), 1);
      repeat (200) @(negedge clk);
      check("midrst_queue", exp_q.size(), 0);

      offer(8'hE4, 1'b1, h);
      push_sof(h); push_byte(h, 0, 8'hE4); push_eof(h, 1, 1'b0);
      wait_idle("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iso15693_tx_encoder.md
ISO15693_TX_ENCODER -- requirements
Module: iso15693_tx_encoder

Interface
REQ-001 SHALL have: ck_1356meg  in  1  13.56 MHz carrier clock; all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset; one clock, asynchronous active-low reset.
REQ-003 SHALL have: tx_data  in  8  command byte to encode.
REQ-004 SHALL have: tx_valid  in  1  tx_data/tx_last valid.
REQ-005 SHALL have: tx_last  in  1  byte is final byte of frame.
REQ-006 SHALL have: tx_ready  out  1  holding buffer empty; byte accepted when tx_valid & tx_ready.
REQ-007 SHALL have: mod  out  1  1 = carrier off (100% modulation), drives the modulation input of the HF transmit stage.
REQ-008 SHALL have: busy  out  1  frame in progress (state != IDLE).
REQ-009 SHALL have: frame_done  out  1  one-cycle pulse at end of EOF.
REQ-010 SHALL have: underrun  out  1  one-cycle pulse when frame is closed because no byte was available.

Function
REQ-011 SHALL encode ISO15693 reader-to-tag 1-of-4 coding; slot = 128 ck_1356meg cycles (9.44 us).
REQ-012 SHALL use a 7-bit slot-cycle counter (0..127, wraps) and a 3-bit slot index; mod SHALL change only at slot boundaries.
REQ-013 SHALL implement FSM states IDLE, SOF, DATA, EOF.
REQ-014 IDLE: mod=0; on accepted byte, byte SHALL load directly into the shift register and FSM SHALL enter SOF next cycle (latency 1 cycle from handshake to first SOF cycle).
REQ-015 SOF: 8 slots; mod=1 in slots 0 and 5, 0 otherwise; then DATA.
REQ-016 DATA: each byte = 4 bit-pairs, LSB pair first, each pair 8 slots (1024 cycles); pair value v (0..3) SHALL give mod=1 only in slot 2v+1.
REQ-017 One-entry holding buffer: tx_ready=1 when buffer empty (including IDLE); accepted bytes during SOF/DATA go to buffer; tx_last stored with byte.
REQ-018 At last cycle of 4th pair: if current byte had last=1 -> EOF; else if buffer full -> buffer moves to shift register, gapless next byte, buffer empties same cycle; else -> EOF with underrun pulse.
REQ-019 Simultaneous accept and buffer-to-shift transfer on same cycle SHALL be lossless (new byte lands in buffer).
REQ-020 EOF: 4 slots; mod=1 only in slot 2; at final cycle frame_done=1 for one cycle, FSM to IDLE, counters cleared.
REQ-021 Bytes offered after a tx_last byte is accepted SHALL not be accepted (tx_ready=0) until IDLE.
REQ-022 mod SHALL be registered, glitch-free, and 0 in IDLE, outside pulse slots, and on entry to IDLE.
REQ-023 busy SHALL be 1 from first SOF cycle through last EOF cycle inclusive.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, mod=0, busy=0, tx_ready=0, frame_done=0, underrun=0, counters=0, buffer empty.
REQ-025 tx_ready SHALL rise the first cycle after rst_n deasserts.
REQ-026 Reset mid-frame SHALL abort without EOF; mod=0 asynchronously; no frame_done or underrun pulse.

Verification
REQ-027 Single byte 0x00 last=1 in IDLE -> SOF mod pulses at cycles 1-128 and 641-768 after handshake; four data pulses each in slot 1; EOF pulse in slot 2; frame_done at cycle 1024+4096+512 after handshake.
REQ-028 Byte 0xE4 (pairs 0,1,2,3 LSB first) -> mod pulses in slots 1,3,5,7 of successive pairs.
REQ-029 Three bytes 0x26,0x01,0x00 (last on third) streamed with tx_valid held -> no gap between bytes, exactly 12 pair periods, one frame_done.
REQ-030 Byte 0x55 last=0 then no further data -> EOF follows first byte, underrun and frame_done pulse, back to IDLE.
REQ-031 rst_n pulsed low during DATA slot 3 -> mod=0 within reset, no frame_done, tx_ready=1 cycle after release, next frame encodes correctly.
REQ-032 tx_valid asserted at exact cycle of buffer-to-shift transfer -> byte accepted, encoded next, no loss or duplication.
